// File: rtl/dtm_dbus_async_bridge_pkg.sv
// Shared widths, field offsets and core-side state encoding for the
// DTM <-> Debug Module bus clock-domain bridge.
package dtm_dbus_async_bridge_pkg;

    // Default debug-bus field widths
    localparam int unsigned DEBUG_DATA_BITS_DFLT = 34;
    localparam int unsigned DEBUG_ADDR_BITS_DFLT = 5;
    localparam int unsigned DEBUG_OP_BITS_DFLT   = 2;

    // Derived payload widths for the default configuration
    localparam int unsigned DBUS_REQ_BITS  = DEBUG_OP_BITS_DFLT + DEBUG_ADDR_BITS_DFLT + DEBUG_DATA_BITS_DFLT;
    localparam int unsigned DBUS_RESP_BITS = DEBUG_OP_BITS_DFLT + DEBUG_DATA_BITS_DFLT;

    // Request word is {addr, data, op}; response word is {data, resp}
    localparam int unsigned REQ_OP_LSB    = 0;
    localparam int unsigned REQ_DATA_LSB  = DEBUG_OP_BITS_DFLT;
    localparam int unsigned REQ_ADDR_LSB  = DEBUG_OP_BITS_DFLT + DEBUG_DATA_BITS_DFLT;
    localparam int unsigned RESP_RESP_LSB = 0;
    localparam int unsigned RESP_DATA_LSB = DEBUG_OP_BITS_DFLT;

    // Core-domain handshake state
    typedef enum logic [1:0] {
        CORE_IDLE = 2'd0,
        CORE_REQ  = 2'd1,
        CORE_WAIT = 2'd2
    } core_state_e;

endpackage

// File: rtl/dtm_dbus_async_bridge_sync.sv
// Single-bit synchronizer: SYNC_STAGES-deep flop chain with async reset.
// Also used as a reset-release synchronizer by tying d high.
module dtm_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < 2) begin : g_bad_depth
        $error("dtm_sync_bit: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] chain;

    // Shift the asynchronous input through the chain; reset clears it at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/dtm_dbus_async_bridge.sv
// Toggle-handshake bridge moving one debug-bus transaction at a time from
// the JTAG TCK domain to the Debug Module clock domain and back. Payloads
// sit in holding registers that stay static while the toggles cross.
module dtm_dbus_async_bridge #(
    parameter int unsigned DEBUG_DATA_BITS = dtm_dbus_async_bridge_pkg::DEBUG_DATA_BITS_DFLT,
    parameter int unsigned DEBUG_ADDR_BITS = dtm_dbus_async_bridge_pkg::DEBUG_ADDR_BITS_DFLT,
    parameter int unsigned DEBUG_OP_BITS   = dtm_dbus_async_bridge_pkg::DEBUG_OP_BITS_DFLT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                                                 jtag_TCK,
    input  logic                                                 jtag_TRST,
    input  logic                                                 clock,
    input  logic                                                 dtm_req_valid,
    output logic                                                 dtm_req_ready,
    input  logic [DEBUG_OP_BITS+DEBUG_ADDR_BITS+DEBUG_DATA_BITS-1:0] dtm_req_bits,
    output logic                                                 dtm_resp_valid,
    input  logic                                                 dtm_resp_ready,
    output logic [DEBUG_OP_BITS+DEBUG_DATA_BITS-1:0]             dtm_resp_bits,
    output logic                                                 dbus_req_valid,
    input  logic                                                 dbus_req_ready,
    output logic [DEBUG_OP_BITS+DEBUG_ADDR_BITS+DEBUG_DATA_BITS-1:0] dbus_req_bits,
    input  logic                                                 dbus_resp_valid,
    output logic                                                 dbus_resp_ready,
    input  logic [DEBUG_OP_BITS+DEBUG_DATA_BITS-1:0]             dbus_resp_bits
);

    import dtm_dbus_async_bridge_pkg::*;

    localparam int unsigned REQ_W  = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS;
    localparam int unsigned RESP_W = DEBUG_OP_BITS + DEBUG_DATA_BITS;

    if (DEBUG_ADDR_BITS < 5 || DEBUG_ADDR_BITS > 7) begin : g_bad_addr
        $error("dtm_dbus_async_bridge: DEBUG_ADDR_BITS must be 5..7");
    end

    // TCK-domain state
    logic              outstanding;
    logic              req_tog;
    logic [REQ_W-1:0]  req_hold;
    logic              ack_sync;
    logic              ack_seen;
    logic              req_fire;
    logic              resp_fire;

    // Core-domain state
    logic              core_rst_n;
    logic              core_rst;
    logic              req_sync;
    logic              req_seen;
    logic              ack_tog;
    logic [RESP_W-1:0] resp_hold;
    core_state_e       state;

    assign dtm_req_ready = ~outstanding;
    assign req_fire      = dtm_req_valid & dtm_req_ready;
    assign resp_fire     = dtm_resp_valid & dtm_resp_ready;

    // Hold registers are quasi-static while their toggle crosses
    assign dbus_req_bits = req_hold;
    assign dtm_resp_bits = resp_hold;

    // Core reset asserts with jtag_TRST and releases after SYNC_STAGES clocks
    dtm_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_core_rst_sync (
        .clk (clock),
        .rst (jtag_TRST),
        .d   (1'b1),
        .q   (core_rst_n)
    );
    assign core_rst = ~core_rst_n;

    dtm_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_tog_sync (
        .clk (clock),
        .rst (core_rst),
        .d   (req_tog),
        .q   (req_sync)
    );

    dtm_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_tog_sync (
        .clk (jtag_TCK),
        .rst (jtag_TRST),
        .d   (ack_tog),
        .q   (ack_sync)
    );

    // Accept a DTM request, latch its payload and signal it with a toggle
    always_ff @(posedge jtag_TCK or posedge jtag_TRST) begin
        if (jtag_TRST) begin
            outstanding <= 1'b0;
            req_tog     <= 1'b0;
            req_hold    <= '0;
        end else if (req_fire) begin
            outstanding <= 1'b1;
            req_tog     <= ~req_tog;
            req_hold    <= dtm_req_bits;
        end else if (resp_fire) begin
            outstanding <= 1'b0;
        end
    end

    // Raise the DTM response when the synchronized ack toggle changes
    always_ff @(posedge jtag_TCK or posedge jtag_TRST) begin
        if (jtag_TRST) begin
            ack_seen       <= 1'b0;
            dtm_resp_valid <= 1'b0;
        end else begin
            ack_seen <= ack_sync;
            if (ack_sync != ack_seen) begin
                dtm_resp_valid <= 1'b1;
            end else if (resp_fire) begin
                dtm_resp_valid <= 1'b0;
            end
        end
    end

    // Core FSM: forward the request to the Debug Module and capture its reply
    always_ff @(posedge clock or posedge core_rst) begin
        if (core_rst) begin
            state           <= CORE_IDLE;
            req_seen        <= 1'b0;
            ack_tog         <= 1'b0;
            resp_hold       <= '0;
            dbus_req_valid  <= 1'b0;
            dbus_resp_ready <= 1'b1;
        end else begin
            case (state)
                CORE_IDLE: begin
                    // Any response arriving here is stale and dropped
                    if (req_sync != req_seen) begin
                        req_seen        <= req_sync;
                        state           <= CORE_REQ;
                        dbus_req_valid  <= 1'b1;
                        dbus_resp_ready <= 1'b0;
                    end
                end
                CORE_REQ: begin
                    if (dbus_req_ready) begin
                        state           <= CORE_WAIT;
                        dbus_req_valid  <= 1'b0;
                        dbus_resp_ready <= 1'b1;
                    end
                end
                CORE_WAIT: begin
                    if (dbus_resp_valid) begin
                        resp_hold <= dbus_resp_bits;
                        ack_tog   <= ~ack_tog;
                        state     <= CORE_IDLE;
                    end
                end
                default: begin
                    state           <= CORE_IDLE;
                    dbus_req_valid  <= 1'b0;
                    dbus_resp_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtm_dbus_async_bridge.sv
// Scoreboard bench for dtm_dbus_async_bridge: stimulus pushes expected
// Debug Module requests and DTM responses; monitors pop and compare.
module tb_dtm_dbus_async_bridge;

    logic        jtag_TCK, jtag_TRST, clock;
    logic        dtm_req_valid, dtm_req_ready;
    logic [40:0] dtm_req_bits;
    logic        dtm_resp_valid, dtm_resp_ready;
    logic [35:0] dtm_resp_bits;
    logic        dbus_req_valid, dbus_req_ready;
    logic [40:0] dbus_req_bits;
    logic        dbus_resp_valid, dbus_resp_ready;
    logic [35:0] dbus_resp_bits;

    int n_checks = 0;
    int n_pass   = 0;

    int tck_half = 10;
    int clk_half = 5;
    bit tck_run  = 1'b1;
    bit dm_auto  = 1'b0;
    int bp_cycles = 0;
    bit stale_mode = 1'b0;

    logic [40:0] req_q[$];
    logic [35:0] resp_q[$];
    logic [35:0] dm_q[$];

    // Debug Module model: automatic and manual drivers merged
    logic        dm_rdy_a = 1'b0, dm_vld_a = 1'b0, dm_rdy_m = 1'b0, dm_vld_m = 1'b0;
    logic [35:0] dm_bits_a = '0, dm_bits_m = '0;
    assign dbus_req_ready  = dm_rdy_a | dm_rdy_m;
    assign dbus_resp_valid = dm_vld_a | dm_vld_m;
    assign dbus_resp_bits  = dm_vld_m ? dm_bits_m : dm_bits_a;

    dtm_dbus_async_bridge #(
        .DEBUG_DATA_BITS (34),
        .DEBUG_ADDR_BITS (5),
        .DEBUG_OP_BITS   (2),
        .SYNC_STAGES     (2)
    ) dut (
        .jtag_TCK        (jtag_TCK),
        .jtag_TRST       (jtag_TRST),
        .clock           (clock),
        .dtm_req_valid   (dtm_req_valid),
        .dtm_req_ready   (dtm_req_ready),
        .dtm_req_bits    (dtm_req_bits),
        .dtm_resp_valid  (dtm_resp_valid),
        .dtm_resp_ready  (dtm_resp_ready),
        .dtm_resp_bits   (dtm_resp_bits),
        .dbus_req_valid  (dbus_req_valid),
        .dbus_req_ready  (dbus_req_ready),
        .dbus_req_bits   (dbus_req_bits),
        .dbus_resp_valid (dbus_resp_valid),
        .dbus_resp_ready (dbus_resp_ready),
        .dbus_resp_bits  (dbus_resp_bits)
    );

    // Clock edges: TCK on multiples of 5, core clock offset by 2 so they never coincide
    initial begin
        clock = 1'b0;
        #2;
        forever begin
            #(clk_half);
            clock = ~clock;
        end
    end

    initial begin
        jtag_TCK = 1'b0;
        forever begin
            #(tck_half);
            if (tck_run) jtag_TCK = ~jtag_TCK;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [63:0] act, input string req);
        n_checks++;
        $display("FAIL %s: got %0h, expected %s", name, act, req);
    endtask

    // Request latency: TCK handshake to dbus_req_valid, in core clock edges
    int req_starts = 0;
    int req_seen_n = 0;
    int req_cnt = 0;
    int req_lat = -1;
    bit req_on = 1'b0;
    always @(posedge jtag_TCK) if (dtm_req_valid && dtm_req_ready) req_starts++;
    always @(clock) begin
        if (clock) begin
            if (req_starts != req_seen_n) begin
                req_seen_n = req_starts; req_cnt = 1; req_on = 1'b1;
            end else if (req_on) req_cnt++;
        end else if (req_on && dbus_req_valid) begin
            req_lat = req_cnt; req_on = 1'b0;
        end
    end

    // Response latency: core capture edge to dtm_resp_valid, in TCK edges
    int resp_starts = 0;
    int resp_seen_n = 0;
    int resp_cnt = 0;
    int resp_lat = -1;
    bit resp_on = 1'b0;
    always @(posedge clock) if (dbus_resp_valid && dbus_resp_ready && !stale_mode) resp_starts++;
    always @(jtag_TCK) begin
        if (jtag_TCK) begin
            if (resp_starts != resp_seen_n) begin
                resp_seen_n = resp_starts; resp_cnt = 1; resp_on = 1'b1;
            end else if (resp_on) resp_cnt++;
        end else if (resp_on && dtm_resp_valid) begin
            resp_lat = resp_cnt; resp_on = 1'b0;
        end
    end

    // Monitor: Debug Module side requests
    logic        req_v_prev = 1'b0;
    logic [40:0] cur_req = '0;
    always @(negedge clock) begin
        if (dbus_req_valid && !req_v_prev) begin
            if (req_q.size() == 0) fail_now("dbus_req_unexpected", 64'(dbus_req_bits), "no request");
            else begin
                cur_req = req_q.pop_front();
                check("dbus_req_bits", 64'(dbus_req_bits), 64'(cur_req));
            end
        end else if (dbus_req_valid) begin
            check("dbus_req_stable", 64'(dbus_req_bits), 64'(cur_req));
        end
        req_v_prev = dbus_req_valid;
    end

    // Monitor: DTM side responses
    logic resp_v_prev = 1'b0;
    logic [35:0] exp_resp;
    always @(negedge jtag_TCK) begin
        if (dtm_resp_valid && !resp_v_prev) begin
            if (resp_q.size() == 0) fail_now("dtm_resp_unexpected", 64'(dtm_resp_bits), "no response");
            else begin
                exp_resp = resp_q.pop_front();
                check("dtm_resp_bits", 64'(dtm_resp_bits), 64'(exp_resp));
            end
        end
        resp_v_prev = dtm_resp_valid;
    end

    // Automatic Debug Module responder with optional back-pressure
    initial begin : dm_model
        forever begin
            @(negedge clock);
            if (dm_auto && dbus_req_valid) begin
                repeat (bp_cycles) @(negedge clock);
                dm_rdy_a = 1'b1;
                @(negedge clock);
                dm_rdy_a = 1'b0;
                if (dm_q.size() == 0) fail_now("dm_resp_missing", 0, "queued response");
                else begin
                    dm_bits_a = dm_q.pop_front();
                    dm_vld_a  = 1'b1;
                    @(negedge clock);
                    dm_vld_a  = 1'b0;
                end
            end
        end
    end

    task automatic do_txn(input logic [40:0] req_word, input logic [35:0] dm_word,
                          input logic [40:0] exp_req, input logic [35:0] exp_rsp, input bit with_resp);
        int unsigned k = 0;
        @(negedge jtag_TCK);
        while (!dtm_req_ready && k < 2000) begin
            @(negedge jtag_TCK);
            k++;
        end
        if (!dtm_req_ready) begin
            fail_now("dtm_req_ready_timeout", 0, "ready");
            return;
        end
        dtm_req_bits  = req_word;
        dtm_req_valid = 1'b1;
        req_q.push_back(exp_req);
        if (with_resp) begin
            dm_q.push_back(dm_word);
            resp_q.push_back(exp_rsp);
        end
        @(negedge jtag_TCK);
        dtm_req_valid = 1'b0;
    endtask

    task automatic wait_resp_valid(input string name);
        int unsigned k = 0;
        do begin
            @(negedge jtag_TCK);
            k++;
        end while (!dtm_resp_valid && k < 500);
        if (!dtm_resp_valid) fail_now(name, 0, "dtm_resp_valid");
    endtask

    task automatic wait_idle(input string name);
        int unsigned k = 0;
        while (!(req_q.size() == 0 && resp_q.size() == 0 && dm_q.size() == 0 &&
                 dtm_req_ready && !dtm_resp_valid && !dbus_req_valid) && k < 20000) begin
            #3;
            k++;
        end
        if (k >= 20000) fail_now(name, 64'(req_q.size() + resp_q.size()), "drained bridge");
    endtask

    initial begin : main
        bit seen;
        logic [63:0] r64;
        logic [4:0]  a;
        logic [33:0] d, rd;
        logic [1:0]  op, rr;

        jtag_TRST      = 1'b1;
        dtm_req_valid  = 1'b0;
        dtm_req_bits   = '0;
        dtm_resp_ready = 1'b1;

        // Reset with both clocks running
        repeat (5) @(negedge jtag_TCK);
        check("rst_dtm_req_ready",   dtm_req_ready,   1);
        check("rst_dtm_resp_valid",  dtm_resp_valid,  0);
        check("rst_dtm_resp_bits",   dtm_resp_bits,   0);
        check("rst_dbus_req_valid",  dbus_req_valid,  0);
        check("rst_dbus_req_bits",   dbus_req_bits,   0);
        check("rst_dbus_resp_ready", dbus_resp_ready, 1);
        jtag_TRST = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (dbus_req_valid) seen = 1'b1;
        end
        check("post_rst_dbus_req_idle", seen, 0);

        // Read with an immediately ready Debug Module
        dm_auto = 1'b1;
        bp_cycles = 0;
        dtm_resp_ready = 1'b0;
        do_txn({5'h10, 34'h0, 2'b01}, {34'h0_1234_5678, 2'b00},
               41'h100_0000_0001, 36'h0_48D1_59E0, 1'b1);
        wait_resp_valid("read_resp_timeout");
        @(negedge jtag_TCK);
        check("read_req_latency",  64'(req_lat),  3);
        check("read_resp_latency", 64'(resp_lat), 3);
        repeat (2) @(negedge jtag_TCK);
        check("read_resp_held",      dtm_resp_valid, 1);
        check("read_resp_bits_held", dtm_resp_bits,  36'h0_48D1_59E0);
        check("read_req_ready_busy", dtm_req_ready,  0);
        dtm_resp_ready = 1'b1;
        @(negedge jtag_TCK);
        check("read_resp_cleared",   dtm_resp_valid, 0);
        check("read_req_ready_free", dtm_req_ready,  1);
        wait_idle("read_idle_timeout");

        // Back-pressure: Debug Module stalls 20 cycles, second DTM request ignored
        bp_cycles = 20;
        do_txn({5'h07, 34'h2_AAAA_5555, 2'b10}, {34'h1_0000_0001, 2'b00},
               41'h7A_AAA9_5556, 36'h4_0000_0004, 1'b1);
        dtm_req_bits  = 41'h1F_0F0F_0F0F;
        dtm_req_valid = 1'b1;
        repeat (6) begin
            @(negedge jtag_TCK);
            check("bp_dtm_req_ready", dtm_req_ready, 0);
        end
        dtm_req_valid = 1'b0;
        check("bp_dbus_req_valid_held", dbus_req_valid, 1);
        wait_idle("bp_idle_timeout");
        bp_cycles = 0;

        // Random traffic at TCK:clock ratios 1:7 then 7:1
        for (int unsigned r = 0; r < 2; r++) begin
            if (r == 0) begin tck_half = 35; clk_half = 5;  end
            else        begin tck_half = 5;  clk_half = 35; end
            for (int unsigned i = 0; i < 100; i++) begin
                a  = 5'($urandom());
                op = 2'($urandom());
                rr = 2'($urandom());
                r64 = {$urandom(), $urandom()}; d  = r64[33:0];
                r64 = {$urandom(), $urandom()}; rd = r64[33:0];
                bp_cycles = int'($urandom_range(0, 3));
                do_txn({a, d, op}, {rd, rr}, {a, d, op}, {rd, rr}, 1'b1);
            end
            wait_idle("ratio_idle_timeout");
        end
        tck_half = 10;
        clk_half = 5;
        bp_cycles = 0;

        // TRST while the core waits for the Debug Module response
        dm_auto = 1'b0;
        do_txn({5'h03, 34'h0_0000_00FF, 2'b01}, '0, 41'h30_0000_03FD, '0, 1'b0);
        seen = 1'b0;
        for (int unsigned k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            if (dbus_req_valid) seen = 1'b1;
        end
        if (!seen) fail_now("abort_req_timeout", 0, "dbus_req_valid");
        dm_rdy_m = 1'b1;
        @(negedge clock);
        dm_rdy_m = 1'b0;
        repeat (2) @(negedge clock);
        jtag_TRST = 1'b1;
        repeat (3) @(negedge jtag_TCK);
        check("abort_rst_dtm_req_ready",   dtm_req_ready,   1);
        check("abort_rst_dbus_req_valid",  dbus_req_valid,  0);
        check("abort_rst_dbus_resp_ready", dbus_resp_ready, 1);
        jtag_TRST = 1'b0;
        repeat (5) @(negedge clock);
        stale_mode = 1'b1;
        dm_bits_m  = {34'h3_FFFF_0000, 2'b10};
        dm_vld_m   = 1'b1;
        @(negedge clock);
        dm_vld_m   = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge jtag_TCK);
            if (dtm_resp_valid) seen = 1'b1;
        end
        check("abort_stale_resp_dropped", seen, 0);
        stale_mode = 1'b0;
        dm_auto = 1'b1;
        do_txn({5'h11, 34'h0_0000_0002, 2'b10}, {34'h0_0000_0003, 2'b01},
               41'h110_0000_000A, 36'h0_0000_000D, 1'b1);
        wait_idle("abort_next_idle_timeout");

        // TCK stalls while the response is captured in the core domain
        do_txn({5'h1F, 34'h3_FFFF_FFFF, 2'b11}, {34'h2_0000_0000, 2'b11},
               41'h1FF_FFFF_FFFF, 36'h8_0000_0003, 1'b1);
        tck_run = 1'b0;
        repeat (30) @(negedge clock);
        check("stall_resp_pending",     dtm_resp_valid,  0);
        check("stall_core_back_idle",   dbus_resp_ready, 1);
        tck_run = 1'b1;
        wait_resp_valid("stall_resp_timeout");
        @(negedge jtag_TCK);
        check("stall_resp_latency", 64'(resp_lat), 3);
        wait_idle("stall_idle_timeout");

        check("queues_drained", 64'(req_q.size() + resp_q.size() + dm_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
